// File: rtl/pc_gen_pkg.sv
// Shared NPC definitions: boot address and fetch-PC generator state encodings.
package pc_gen_pkg;

    localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [63:0] PC_STEP              = 64'd4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    function automatic logic is_aligned(input logic [63:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-PC bundle between the PC generator (master) and fetch/execute (slave).
interface pc_gen_if;

    logic        fetch_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt_req;
    logic [63:0] pc;
    logic        pc_valid;
    logic        halted;
    logic        misalign_err;
    logic [63:0] fetch_cnt;

    modport master (
        input  fetch_ready, redirect_valid, redirect_pc, halt_req,
        output pc, pc_valid, halted, misalign_err, fetch_cnt
    );

    modport slave (
        output fetch_ready, redirect_valid, redirect_pc, halt_req,
        input  pc, pc_valid, halted, misalign_err, fetch_cnt
    );

endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT -> RUN -> HALT with redirect, stall and sticky halt.
// All outputs registered; every input takes effect on the outputs one cycle later.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [63:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    pc_gen_if.master  bus
);

    state_t      state_q, state_n;
    logic [63:0] pc_q, pc_n;
    logic [63:0] cnt_q, cnt_n;
    logic        pc_valid_q, pc_valid_n;
    logic        halted_q, halted_n;
    logic        misalign_q, misalign_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            cnt_q      <= 64'd0;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            pc_q       <= pc_n;
            cnt_q      <= cnt_n;
            pc_valid_q <= pc_valid_n;
            halted_q   <= halted_n;
            misalign_q <= misalign_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        pc_n       = pc_q;
        cnt_n      = cnt_q;
        misalign_n = misalign_q;
        case (state_q)
            BOOT: begin
                state_n = RUN;
                pc_n    = RESET_VECTOR;
            end
            RUN: begin
                // pc_valid is 1 throughout RUN, so fetch_ready alone marks a handshake
                if (bus.fetch_ready) begin
                    cnt_n = cnt_q + 64'd1;
                end
                if (bus.halt_req) begin
                    state_n = HALT;
                end else if (bus.redirect_valid) begin
                    if (is_aligned(bus.redirect_pc)) begin
                        pc_n = bus.redirect_pc;
                    end else begin
                        misalign_n = 1'b1;
                        state_n    = HALT;
                    end
                end else if (bus.fetch_ready) begin
                    pc_n = pc_q + PC_STEP;
                end
            end
            HALT: begin
                state_n = HALT;
            end
            default: begin
                state_n = BOOT;
            end
        endcase
        pc_valid_n = (state_n == RUN);
        halted_n   = (state_n == HALT);
    end

    assign bus.pc           = pc_q;
    assign bus.pc_valid     = pc_valid_q;
    assign bus.halted       = halted_q;
    assign bus.misalign_err = misalign_q;
    assign bus.fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_pc_gen;

    localparam logic [63:0] RV = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic        vld;
        logic        halted;
        logic        mis;
        logic [63:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    pc_gen_if bus ();

    pc_gen #(.RESET_VECTOR(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    function automatic exp_t mk(input logic [63:0] pc, input logic vld, input logic h,
                                input logic m, input logic [63:0] cnt);
        exp_t e;
        e.pc = pc; e.vld = vld; e.halted = h; e.mis = m; e.cnt = cnt;
        return e;
    endfunction

    // Inputs apply to the cycle before the next rising edge; e is the output state after it.
    task automatic step(input logic rst, input logic fr, input logic rv,
                        input logic [63:0] rpc, input logic hr, input exp_t e);
        @(negedge clk);
        reset              = rst;
        bus.fetch_ready    = fr;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.halt_req       = hr;
        sb.push_back(e);
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = mk(bus.pc, bus.pc_valid, bus.halted, bus.misalign_err, bus.fetch_cnt);
                step_no++;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL step%0d: got pc=%h vld=%b halted=%b mis=%b cnt=%0d, want pc=%h vld=%b halted=%b mis=%b cnt=%0d",
                             step_no, a.pc, a.vld, a.halted, a.mis, a.cnt,
                             e.pc, e.vld, e.halted, e.mis, e.cnt);
                end
            end
        end
    end

    initial begin : stim
        reset = 1'b1;
        bus.fetch_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 64'd0;
        bus.halt_req = 1'b0;

        // reset 3 cycles, then BOOT cycle (pc_valid=0) and sequential fetch
        repeat (3) step(1, 1, 0, 0, 0, mk(RV, 0, 0, 0, 0));
        step(0, 1, 0, 0, 0, mk(RV,              1, 0, 0, 0));
        step(0, 1, 0, 0, 0, mk(RV + 64'h4,      1, 0, 0, 1));
        step(0, 1, 0, 0, 0, mk(RV + 64'h8,      1, 0, 0, 2));
        step(0, 1, 0, 0, 0, mk(RV + 64'hC,      1, 0, 0, 3));
        step(0, 1, 0, 0, 0, mk(RV + 64'h10,     1, 0, 0, 4));
        // stall 4 cycles, then release
        repeat (4) step(0, 0, 0, 0, 0, mk(RV + 64'h10, 1, 0, 0, 4));
        step(0, 1, 0, 0, 0, mk(RV + 64'h14,     1, 0, 0, 5));
        // redirect during stall, fetch, redirect with handshake
        step(0, 0, 1, 64'h8000_1000, 0, mk(64'h8000_1000, 1, 0, 0, 5));
        step(0, 1, 0, 0,             0, mk(64'h8000_1004, 1, 0, 0, 6));
        step(0, 1, 1, 64'h8000_1000, 0, mk(64'h8000_1000, 1, 0, 0, 7));
        // wrap of pc at top of address space
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, mk(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 7));
        step(0, 1, 0, 0, 0, mk(64'h0, 1, 0, 0, 8));
        step(0, 1, 0, 0, 0, mk(64'h4, 1, 0, 0, 9));
        // halt beats redirect and handshake pc update; handshake still counted
        step(0, 1, 1, 64'h100, 1, mk(64'h4, 0, 1, 0, 10));
        step(0, 1, 1, 64'h200, 0, mk(64'h4, 0, 1, 0, 10));
        step(0, 1, 0, 0,       1, mk(64'h4, 0, 1, 0, 10));
        // reset in HALT; BOOT ignores redirect and halt
        step(1, 1, 1, 64'h300, 1, mk(RV, 0, 0, 0, 0));
        step(0, 1, 1, 64'h300, 1, mk(RV, 1, 0, 0, 0));
        // misaligned redirect: sticky error, halt, pc held, later redirects ignored
        step(0, 0, 1, 64'h8000_1002, 0, mk(RV, 0, 1, 1, 0));
        step(0, 1, 1, 64'h8000_2000, 0, mk(RV, 0, 1, 1, 0));
        step(0, 1, 0, 0,             0, mk(RV, 0, 1, 1, 0));
        // reset clears sticky error, then reset mid-stall and mid-redirect
        step(1, 0, 0, 0, 0, mk(RV, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, mk(RV, 1, 0, 0, 0));
        step(0, 0, 0, 0, 0, mk(RV, 1, 0, 0, 0));
        step(1, 0, 0, 0, 0, mk(RV, 0, 0, 0, 0));
        step(0, 1, 0, 0, 0, mk(RV, 1, 0, 0, 0));
        step(0, 1, 0, 0, 0, mk(RV + 64'h4, 1, 0, 0, 1));
        step(1, 1, 1, 64'h8000_3000, 0, mk(RV, 0, 0, 0, 0));

        // let the monitor drain, bounded
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
